vga_timing_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 47 ++++
 rtl/vga_sync_counter.sv | 47 ++++
 rtl/vga_timing_gen.sv | 156 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA raster timing defaults, region/coordinate types and the region decode helper.
package vga_pkg;

  localparam int unsigned VGA_COORD_W  = 10;
  localparam int unsigned VGA_COLOR_W  = 8;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} vga_region_t;

  typedef logic [VGA_COORD_W-1:0] vga_coord_t;

  typedef struct packed {
    logic [VGA_COLOR_W-1:0] r;
    logic [VGA_COLOR_W-1:0] g;
    logic [VGA_COLOR_W-1:0] b;
  } vga_rgb_t;

  // Regions are laid out ACTIVE -> FRONT -> SYNC -> BACK from count 0.
  function automatic vga_region_t vga_region(input vga_coord_t  cnt,
                                             input int unsigned act_len,
                                             input int unsigned fp_len,
                                             input int unsigned sync_len);
    vga_region_t reg_v;
    if (cnt < vga_coord_t'(act_len)) begin
      reg_v = ACTIVE;
    end else if (cnt < vga_coord_t'(act_len + fp_len)) begin
      reg_v = FRONT;
    end else if (cnt < vga_coord_t'(act_len + fp_len + sync_len)) begin
      reg_v = SYNC;
    end else begin
      reg_v = BACK;
    end
    return reg_v;
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// One raster axis: wrapping position counter with region decode, used for both lines and frames.
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int unsigned ACTIVE_LEN = VGA_H_ACTIVE,
  parameter int unsigned FP_LEN     = VGA_H_FP,
  parameter int unsigned SYNC_LEN   = VGA_H_SYNC,
  parameter int unsigned BP_LEN     = VGA_H_BP
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en_i,
  output logic [VGA_COORD_W-1:0] cnt_o,
  output logic                   wrap_c_o,
  output vga_region_t            region_c_o,
  output logic                   sync_c_o
);

  localparam int unsigned TOTAL = ACTIVE_LEN + FP_LEN + SYNC_LEN + BP_LEN;

  vga_coord_t cnt_q;
  vga_coord_t cnt_d;
  logic       at_end_c;

  assign at_end_c = (cnt_q == vga_coord_t'(TOTAL - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = at_end_c ? '0 : cnt_q + vga_coord_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign wrap_c_o   = en_i & at_end_c;
  assign region_c_o = vga_region(cnt_q, ACTIVE_LEN, FP_LEN, SYNC_LEN);
  assign sync_c_o   = (region_c_o == SYNC);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: drives x/y to the colour generator and a registered, blank-gated DAC port.
// Build option VGA_PIXEL_DIV2_EN: clk is twice the pixel rate and pixels advance every other clk.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [VGA_COORD_W-1:0] x,
  output logic [VGA_COORD_W-1:0] y,
  input  logic [VGA_COLOR_W-1:0] r_in,
  input  logic [VGA_COLOR_W-1:0] g_in,
  input  logic [VGA_COLOR_W-1:0] b_in,
  output logic [VGA_COLOR_W-1:0] vga_r,
  output logic [VGA_COLOR_W-1:0] vga_g,
  output logic [VGA_COLOR_W-1:0] vga_b,
  output logic                   vga_hs,
  output logic                   vga_vs,
  output logic                   vga_blank_n,
  output logic                   vga_sync_n,
  output logic                   vga_clk,
  output logic                   frame_start
);

  logic pix_en_c;

`ifdef VGA_PIXEL_DIV2_EN
  // Divider rises mid-pixel, so the DAC samples the outputs registered on the previous pix_en.
  logic div_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= 1'b0;
    end else begin
      div_q <= ~div_q;
    end
  end

  assign pix_en_c = div_q;
  assign vga_clk  = div_q;
`else
  assign pix_en_c = 1'b1;
  assign vga_clk  = ~clk;
`endif

  vga_coord_t  hcnt;
  vga_coord_t  vcnt;
  logic        h_wrap_c;
  logic        v_wrap_c;
  vga_region_t h_region_c;
  vga_region_t v_region_c;
  logic        h_sync_c;
  logic        v_sync_c;
  logic        active_c;

  vga_sync_counter #(
    .ACTIVE_LEN (H_ACTIVE),
    .FP_LEN     (H_FP),
    .SYNC_LEN   (H_SYNC),
    .BP_LEN     (H_BP)
  ) u_hcnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (pix_en_c),
    .cnt_o      (hcnt),
    .wrap_c_o   (h_wrap_c),
    .region_c_o (h_region_c),
    .sync_c_o   (h_sync_c)
  );

  vga_sync_counter #(
    .ACTIVE_LEN (V_ACTIVE),
    .FP_LEN     (V_FP),
    .SYNC_LEN   (V_SYNC),
    .BP_LEN     (V_BP)
  ) u_vcnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (h_wrap_c),
    .cnt_o      (vcnt),
    .wrap_c_o   (v_wrap_c),
    .region_c_o (v_region_c),
    .sync_c_o   (v_sync_c)
  );

  assign active_c = (h_region_c == ACTIVE) && (v_region_c == ACTIVE);

  vga_rgb_t rgb_q;
  vga_rgb_t rgb_d;
  logic     hs_q;
  logic     hs_d;
  logic     vs_q;
  logic     vs_d;
  logic     blank_n_q;
  logic     blank_n_d;
  logic     fs_q;
  logic     fs_d;
  logic     at_origin_q;
  logic     at_origin_d;

  // at_origin_q tracks "counters sit at (0,0)" without a full-width compare on both axes.
  always_comb begin
    rgb_d       = rgb_q;
    hs_d        = hs_q;
    vs_d        = vs_q;
    blank_n_d   = blank_n_q;
    at_origin_d = at_origin_q;
    fs_d        = 1'b0;
    if (pix_en_c) begin
      rgb_d       = active_c ? vga_rgb_t'({r_in, g_in, b_in}) : '0;
      hs_d        = ~h_sync_c;
      vs_d        = ~v_sync_c;
      blank_n_d   = active_c;
      at_origin_d = v_wrap_c;
      fs_d        = at_origin_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q       <= '0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      blank_n_q   <= 1'b0;
      fs_q        <= 1'b0;
      at_origin_q <= 1'b1;
    end else begin
      rgb_q       <= rgb_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      blank_n_q   <= blank_n_d;
      fs_q        <= fs_d;
      at_origin_q <= at_origin_d;
    end
  end

  assign x           = hcnt;
  assign y           = vcnt;
  assign vga_r       = rgb_q.r;
  assign vga_g       = rgb_q.g;
  assign vga_b       = rgb_q.b;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign vga_sync_n  = 1'b0;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a shrunken-raster instance (A) and a default 640x480 instance (B) vs a pixel-index model.
`timescale 1ns/1ps
module tb_vga_timing_gen;

`ifdef VGA_PIXEL_DIV2_EN
  localparam int DIV = 2;
`else
  localparam int DIV = 1;
`endif
  localparam int RUN1 = 8417;
  localparam int RUN2 = 1200;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [9:0] a_x, a_y, b_x, b_y;
  logic [7:0] a_ri, a_gi, a_bi, b_ri, b_gi, b_bi;
  logic [7:0] a_r, a_g, a_b, b_r, b_g, b_b;
  logic a_hs, a_vs, a_bl, a_sn, a_vc, a_fs;
  logic b_hs, b_vs, b_bl, b_sn, b_vc, b_fs;

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .x(a_x), .y(a_y),
    .r_in(a_ri), .g_in(a_gi), .b_in(a_bi),
    .vga_r(a_r), .vga_g(a_g), .vga_b(a_b),
    .vga_hs(a_hs), .vga_vs(a_vs), .vga_blank_n(a_bl), .vga_sync_n(a_sn),
    .vga_clk(a_vc), .frame_start(a_fs)
  );

  vga_timing_gen u_b (
    .clk(clk), .rst_n(rst_n), .x(b_x), .y(b_y),
    .r_in(b_ri), .g_in(b_gi), .b_in(b_bi),
    .vga_r(b_r), .vga_g(b_g), .vga_b(b_b),
    .vga_hs(b_hs), .vga_vs(b_vs), .vga_blank_n(b_bl), .vga_sync_n(b_sn),
    .vga_clk(b_vc), .frame_start(b_fs)
  );

  // Raster geometry for each instance: index 0 = A, 1 = B.
  int ha [2] = '{16, 640};
  int hf [2] = '{4, 16};
  int hsl[2] = '{6, 96};
  int hb [2] = '{4, 48};
  int va [2] = '{10, 480};
  int vf [2] = '{2, 10};
  int vsl[2] = '{2, 2};
  int vb [2] = '{3, 33};

  int e;
  logic [7:0] dr[2], dg[2], db[2];
  logic [7:0] er[2], eg[2], eb[2];
  int hs_run[2], vs_run[2], last_fs[2], fs_cnt[2];
  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    e = 0;
    for (int d = 0; d < 2; d++) begin
      dr[d] = 8'h0; dg[d] = 8'h0; db[d] = 8'h0;
      er[d] = 8'h0; eg[d] = 8'h0; eb[d] = 8'h0;
      hs_run[d] = 0; vs_run[d] = 0; last_fs[d] = -1; fs_cnt[d] = 0;
    end
  endtask

  task automatic drive();
    a_ri = dr[0]; a_gi = dg[0]; a_bi = db[0];
    b_ri = dr[1]; b_gi = dg[1]; b_bi = db[1];
  endtask

  task automatic rst_chk_dut(input string t, input logic [9:0] ox, oy, input logic [7:0] orr, og, ob,
                             input logic ohs, ovs, obl, ofs);
    chk({t, ".x"},     32'(ox),  0);
    chk({t, ".y"},     32'(oy),  0);
    chk({t, ".r"},     32'(orr), 0);
    chk({t, ".g"},     32'(og),  0);
    chk({t, ".b"},     32'(ob),  0);
    chk({t, ".hs"},    32'(ohs), 1);
    chk({t, ".vs"},    32'(ovs), 1);
    chk({t, ".blank"}, 32'(obl), 0);
    chk({t, ".fs"},    32'(ofs), 0);
  endtask

  // Expected state after e clk edges since release: k = e/DIV pixels advanced,
  // DAC shows pixel k-1 (row-major over the full raster).
  task automatic step_dut(input int d, input logic [9:0] ox, oy, input logic [7:0] orr, og, ob,
                          input logic ohs, ovs, obl, osn, ovc, ofs);
    int ht, vt, k, p, hx, vy;
    logic pe, act, ehs, evs, efs;
    string n;
    n  = (d == 0) ? "A" : "B";
    ht = ha[d] + hf[d] + hsl[d] + hb[d];
    vt = va[d] + vf[d] + vsl[d] + vb[d];
    k  = e / DIV;
    pe = (e > 0) && (e % DIV == 0);
    p  = k - 1;
    hx = (k > 0) ? p % ht : 0;
    vy = (k > 0) ? (p / ht) % vt : 0;
    act = (k > 0) && (hx < ha[d]) && (vy < va[d]);
    ehs = !((k > 0) && (hx >= ha[d] + hf[d]) && (hx < ha[d] + hf[d] + hsl[d]));
    evs = !((k > 0) && (vy >= va[d] + vf[d]) && (vy < va[d] + vf[d] + vsl[d]));
    efs = pe && (p % (ht * vt) == 0);
    if (pe) begin
      er[d] = act ? dr[d] : 8'h0;
      eg[d] = act ? dg[d] : 8'h0;
      eb[d] = act ? db[d] : 8'h0;
    end
    chk({n, ".x"},     32'(ox),  k % ht);
    chk({n, ".y"},     32'(oy),  (k / ht) % vt);
    chk({n, ".blank"}, 32'(obl), 32'(act));
    chk({n, ".hs"},    32'(ohs), 32'(ehs));
    chk({n, ".vs"},    32'(ovs), 32'(evs));
    chk({n, ".r"},     32'(orr), 32'(er[d]));
    chk({n, ".g"},     32'(og),  32'(eg[d]));
    chk({n, ".b"},     32'(ob),  32'(eb[d]));
    chk({n, ".syncn"}, 32'(osn), 0);
    chk({n, ".fs"},    32'(ofs), 32'(efs));
    chk({n, ".vclk"},  32'(ovc), (DIV == 1) ? 1 : e % 2);
    if (d == 1 && pe && p == 10 * ht + 100) chk("B.r_at_100_10", 32'(orr), 100);
    if (pe) begin
      if (!ohs) hs_run[d]++;
      else if (hs_run[d] > 0) begin
        chk({n, ".hs_width"}, hs_run[d], hsl[d]);
        hs_run[d] = 0;
      end
      if (!ovs) vs_run[d]++;
      else if (vs_run[d] > 0) begin
        chk({n, ".vs_width"}, vs_run[d], vsl[d] * ht);
        vs_run[d] = 0;
      end
    end
    if (ofs) begin
      if (last_fs[d] >= 0) chk({n, ".fs_gap"}, e - last_fs[d], ht * vt * DIV);
      last_fs[d] = e;
      fs_cnt[d]++;
    end
    // Next colour: B returns x[7:0]; A returns white for its first frame, random afterwards.
    if (d == 1) dr[d] = 8'(k % ht);
    else        dr[d] = (k < ht * vt) ? 8'hFF : 8'($urandom);
    dg[d] = (d == 0 && k < ht * vt) ? 8'hFF : 8'($urandom);
    db[d] = (d == 0 && k < ht * vt) ? 8'hFF : 8'($urandom);
  endtask

  task automatic run(input int n_clk);
    for (int i = 0; i < n_clk; i++) begin
      @(negedge clk);
      #1;
      e++;
      step_dut(0, a_x, a_y, a_r, a_g, a_b, a_hs, a_vs, a_bl, a_sn, a_vc, a_fs);
      step_dut(1, b_x, b_y, b_r, b_g, b_b, b_hs, b_vs, b_bl, b_sn, b_vc, b_fs);
      drive();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    model_reset();
    drive();
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    rst_chk_dut("rst.A", a_x, a_y, a_r, a_g, a_b, a_hs, a_vs, a_bl, a_fs);
    rst_chk_dut("rst.B", b_x, b_y, b_r, b_g, b_b, b_hs, b_vs, b_bl, b_fs);
    rst_n = 1'b1;

    run(RUN1 * DIV);
    chk("A.fs_count", fs_cnt[0], (RUN1 + 509) / 510);

    // Asynchronous reset mid-line / mid-frame, away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    rst_chk_dut("arst.A", a_x, a_y, a_r, a_g, a_b, a_hs, a_vs, a_bl, a_fs);
    rst_chk_dut("arst.B", b_x, b_y, b_r, b_g, b_b, b_hs, b_vs, b_bl, b_fs);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    model_reset();
    drive();
    rst_n = 1'b1;

    run(RUN2 * DIV);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
